// File: rtl/i2c_eeprom_rd_arbiter_if.sv
// Request/response and AXI read-channel signals of the EEPROM read arbiter.
// Handshake: a transfer happens on every clock edge where valid and ready are both high.
interface i2c_eeprom_rd_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic [1:0]  rsp_resp;
  logic [1:0]  MASTER_RD_ADDR_ID;
  logic [31:0] MASTER_RD_ADDR;
  logic [7:0]  MASTER_RD_ADDR_LEN;
  logic [1:0]  MASTER_RD_ADDR_BURST;
  logic        MASTER_RD_ADDR_VALID;
  logic        MASTER_RD_ADDR_READY;
  logic [31:0] MASTER_RD_DATA;
  logic [1:0]  MASTER_RD_DATA_RESP;
  logic        MASTER_RD_DATA_LAST;
  logic        MASTER_RD_DATA_VALID;
  logic        MASTER_RD_DATA_READY;

  modport master (
    input  req_valid, req_addr, req_len,
           MASTER_RD_ADDR_READY, MASTER_RD_DATA, MASTER_RD_DATA_RESP,
           MASTER_RD_DATA_LAST, MASTER_RD_DATA_VALID,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_resp,
           MASTER_RD_ADDR_ID, MASTER_RD_ADDR, MASTER_RD_ADDR_LEN, MASTER_RD_ADDR_BURST,
           MASTER_RD_ADDR_VALID, MASTER_RD_DATA_READY
  );

  modport slave (
    output req_valid, req_addr, req_len,
           MASTER_RD_ADDR_READY, MASTER_RD_DATA, MASTER_RD_DATA_RESP,
           MASTER_RD_DATA_LAST, MASTER_RD_DATA_VALID,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_resp,
           MASTER_RD_ADDR_ID, MASTER_RD_ADDR, MASTER_RD_ADDR_LEN, MASTER_RD_ADDR_BURST,
           MASTER_RD_ADDR_VALID, MASTER_RD_DATA_READY
  );
endinterface

// File: rtl/i2c_eeprom_rd_arbiter.sv
// Round-robin arbiter sharing one AXI INCR read path to the I2C EEPROM slave
// between two requesters, with a fixed idle gap after every burst.
module i2c_eeprom_rd_arbiter #(
  parameter logic [31:0] I2C_EEPROM_SLAVE_BASEADDR = 32'h3000_0000,
  parameter logic [6:0]  I2C_DEV_ADDR              = 7'b1010_011,
  parameter int          GAP_CYCLES                = 20480
) (
  input  logic                          clk,
  input  logic                          rst,
  i2c_eeprom_rd_arbiter_if.master       bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, GAP = 2'd3} state_t;

  // GAP_CYCLES of 0 and 1 both give a single gap cycle.
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic        rr_ptr;
  logic [15:0] cnt;
  logic [15:0] addr_q;
  logic [7:0]  len_q;
  logic        gnt_q;
  logic        gnt;
  logic        accept;
  logic        beat;
  logic        unused_data_bits;

  always_comb begin
    state_nxt = state;
    gnt       = rr_ptr;
    accept    = 1'b0;
    case (state)
      IDLE: if (|bus.req_valid) begin
        gnt       = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        accept    = 1'b1;
        state_nxt = ADDR;
      end
      ADDR: if (bus.MASTER_RD_ADDR_READY) state_nxt = DATA;
      DATA: if (bus.MASTER_RD_DATA_VALID && bus.MASTER_RD_DATA_LAST) state_nxt = GAP;
      GAP:  if (cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      cnt    <= '0;
      addr_q <= '0;
      len_q  <= '0;
      gnt_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_q  <= gnt;
        rr_ptr <= ~gnt;
        addr_q <= gnt ? bus.req_addr[31:16] : bus.req_addr[15:0];
        len_q  <= gnt ? bus.req_len[15:8] : bus.req_len[7:0];
      end
      if (state == GAP) cnt <= (state_nxt == IDLE) ? 16'd0 : cnt + 16'd1;
    end
  end

  assign bus.req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  // Response fields are zeroed between beats so idle cycles show all-zero outputs.
  assign beat          = (state == DATA) && bus.MASTER_RD_DATA_VALID;
  assign bus.rsp_valid = beat ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = beat ? bus.MASTER_RD_DATA[7:0] : 8'd0;
  assign bus.rsp_last  = beat & bus.MASTER_RD_DATA_LAST;
  assign bus.rsp_resp  = beat ? bus.MASTER_RD_DATA_RESP : 2'b00;

  assign bus.MASTER_RD_ADDR_ID    = 2'b00;
  assign bus.MASTER_RD_ADDR       = {I2C_EEPROM_SLAVE_BASEADDR[31:24], I2C_DEV_ADDR, 1'b1, addr_q};
  assign bus.MASTER_RD_ADDR_LEN   = len_q;
  assign bus.MASTER_RD_ADDR_BURST = 2'b01;
  assign bus.MASTER_RD_ADDR_VALID = (state == ADDR);
  assign bus.MASTER_RD_DATA_READY = (state == DATA);

  assign dbg_state        = state;
  assign unused_data_bits = ^bus.MASTER_RD_DATA[31:8];

endmodule
